fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_if.sv | 39 +++
 rtl/fetch_queue.sv | 113 +++++++++++
 tb/tb_fetch_queue.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// ---------------------------------------------------------------------------
// fetch_queue_if -- bundle of the fetch/decode handshake signals of
// fetch_queue.
//   redirect, redirectPC       : flush the buffer and restart fetch at a new PC
//   imemAddr/imemData/imemReady: instruction memory port (combinational data)
//   outValid/outReady          : head-entry handshake toward decode
//   PCOut/IROut/incPCOut       : head entry {PC, instruction, PC+1}
//   count                      : buffer occupancy
// modport master : the fetch queue itself
// modport slave  : the surrounding core (memory model, decode, control)
// ---------------------------------------------------------------------------
interface fetch_queue_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             redirect;
  logic [WIDTH-1:0] redirectPC;
  logic [WIDTH-1:0] imemAddr;
  logic [WIDTH-1:0] imemData;
  logic             imemReady;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] PCOut;
  logic [WIDTH-1:0] IROut;
  logic [WIDTH-1:0] incPCOut;
  logic [CW-1:0]    count;

  modport master (
    input  redirect, redirectPC, imemData, imemReady, outReady,
    output imemAddr, outValid, PCOut, IROut, incPCOut, count
  );

  modport slave (
    output redirect, redirectPC, imemData, imemReady, outReady,
    input  imemAddr, outValid, PCOut, IROut, incPCOut, count
  );
endinterface

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue -- instruction prefetch buffer.
// Holds the fetch PC and a DEPTH-entry FIFO of {PC, IR, PC+1}. One word is
// fetched per cycle whenever memory is ready and there is room (or a slot is
// freed by a same-cycle pop). redirect flushes the buffer and reloads the PC.
//
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset (PC <= RESET_PC, buffer empty)
//   bus   : fetch_queue_if.master (memory port, decode handshake, redirect)
//
// Configuration macro: FETCH_BYPASS_EN
//   When defined, an empty buffer forwards the word being fetched straight to
//   the outputs in the same cycle; if decode takes it, no buffer write occurs.
// ---------------------------------------------------------------------------
module fetch_queue #(
  parameter int               WIDTH    = 16,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic           clk,
  input  logic           reset,
  fetch_queue_if.master  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] ir;
    logic [WIDTH-1:0] inc_pc;
  } entry_t;

  entry_t           r_mem [DEPTH];
  logic [WIDTH-1:0] r_pc;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic   w_empty;
  logic   w_full;
  logic   w_bypass;
  logic   w_pop;
  logic   w_enq;
  logic   w_write;
  logic   w_buf_pop;
  entry_t w_fetch;
  entry_t w_head;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_fetch = '{pc: r_pc, ir: bus.imemData, inc_pc: r_pc + WIDTH'(1)};

`ifdef FETCH_BYPASS_EN
  assign w_bypass = w_empty & ~bus.redirect & bus.imemReady;
`else
  assign w_bypass = 1'b0;
`endif

  // Head selection: bypassed fetch word, buffered head, or zeros when idle.
  // NOTE: every signal written in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_head = '0;
    if (w_bypass)
      w_head = w_fetch;
    else if (!w_empty)
      w_head = r_mem[r_rd_ptr];
  end

  assign bus.outValid = ~w_empty | w_bypass;
  assign bus.PCOut    = w_head.pc;
  assign bus.IROut    = w_head.ir;
  assign bus.incPCOut = w_head.inc_pc;
  assign bus.imemAddr = r_pc;
  assign bus.count    = r_count;

  // A pop frees a slot in the same cycle, so a full buffer can still fetch.
  assign w_pop     = bus.outValid & bus.outReady & ~bus.redirect;
  assign w_enq     = bus.imemReady & ~bus.redirect & (~w_full | w_pop);
  // A bypassed word consumed by decode never touches the buffer.
  assign w_write   = w_enq & ~(w_bypass & w_pop);
  assign w_buf_pop = w_pop & ~w_bypass;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc     <= RESET_PC;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.redirect) begin
      r_pc     <= bus.redirectPC;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq)     r_pc     <= r_pc + WIDTH'(1);
      if (w_write)   r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_buf_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_write) - CW'(w_buf_pop);
    end
  end

  // NOTE: the entry storage is not reset; the pointers and count define
  // which entries are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (!reset && w_write)
      r_mem[r_wr_ptr] <= w_fetch;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue -- directed, table-driven bench for fetch_queue
// (WIDTH=16, DEPTH=4, RESET_PC=0, default build). The instruction memory is
// modelled as imemData = 0x1000 + imemAddr.
// ---------------------------------------------------------------------------
module tb_fetch_queue;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;

  fetch_queue_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  fetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.imemData = 16'h1000 + bus.imemAddr;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        rst;
    logic        redir;
    logic [15:0] rpc;
    logic        rdy;
    logic        ordy;
    int          exp_cnt;
    logic        exp_valid;
    logic [15:0] exp_pc;
    logic [15:0] exp_addr;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic rst, logic redir, logic [15:0] rpc,
                              logic rdy, logic ordy, int cnt, logic vld,
                              logic [15:0] pc, logic [15:0] addr);
    vec_t v;
    v.rst = rst; v.redir = redir; v.rpc = rpc; v.rdy = rdy; v.ordy = ordy;
    v.exp_cnt = cnt; v.exp_valid = vld; v.exp_pc = pc; v.exp_addr = addr;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Drive inputs on the falling edge, let the rising edge act, sample 1 time
  // unit later.
  task automatic step(logic rst, logic redir, logic [15:0] rpc, logic rdy,
                      logic ordy);
    @(negedge clk);
    reset         = rst;
    bus.redirect  = redir;
    bus.redirectPC = rpc;
    bus.imemReady = rdy;
    bus.outReady  = ordy;
    @(posedge clk);
    #1;
  endtask

  // Full observable state check; IR and PC+1 follow from the head PC.
  task automatic check_state(string tag, int cnt, logic vld, logic [15:0] pc,
                             logic [15:0] addr);
    logic [15:0] exp_ir;
    logic [15:0] exp_inc;
    exp_ir  = vld ? 16'(16'h1000 + pc) : 16'h0000;
    exp_inc = vld ? 16'(pc + 16'h0001) : 16'h0000;
    check({tag, ".count"},    32'(bus.count),    32'(cnt));
    check({tag, ".outValid"}, 32'(bus.outValid), 32'(vld));
    check({tag, ".PCOut"},    32'(bus.PCOut),    32'(vld ? pc : 16'h0000));
    check({tag, ".IROut"},    32'(bus.IROut),    32'(exp_ir));
    check({tag, ".incPCOut"}, 32'(bus.incPCOut), 32'(exp_inc));
    check({tag, ".imemAddr"}, 32'(bus.imemAddr), 32'(addr));
  endtask

  initial begin
    reset = 1'b1;
    bus.redirect = 1'b0;
    bus.redirectPC = '0;
    bus.imemReady = 1'b0;
    bus.outReady = 1'b0;

    //   rst redir rpc      rdy ordy  cnt vld pc       addr
    // reset state
    add(1, 0, 16'h0000, 0, 0,  0, 0, 16'h0000, 16'h0000);
    add(1, 0, 16'h0000, 1, 1,  0, 0, 16'h0000, 16'h0000);
    // streaming: one instruction per cycle, count stays 1
    add(0, 0, 16'h0000, 1, 1,  1, 1, 16'h0000, 16'h0001);
    add(0, 0, 16'h0000, 1, 1,  1, 1, 16'h0001, 16'h0002);
    add(0, 0, 16'h0000, 1, 1,  1, 1, 16'h0002, 16'h0003);
    // decode stalled from reset: fill to DEPTH, PC stops at 4, head stable
    add(1, 0, 16'h0000, 1, 0,  0, 0, 16'h0000, 16'h0000);
    add(0, 0, 16'h0000, 1, 0,  1, 1, 16'h0000, 16'h0001);
    add(0, 0, 16'h0000, 1, 0,  2, 1, 16'h0000, 16'h0002);
    add(0, 0, 16'h0000, 1, 0,  3, 1, 16'h0000, 16'h0003);
    add(0, 0, 16'h0000, 1, 0,  4, 1, 16'h0000, 16'h0004);
    add(0, 0, 16'h0000, 1, 0,  4, 1, 16'h0000, 16'h0004);
    add(0, 0, 16'h0000, 1, 0,  4, 1, 16'h0000, 16'h0004);
    // release: full buffer enqueues alongside each pop, order preserved
    add(0, 0, 16'h0000, 1, 1,  4, 1, 16'h0001, 16'h0005);
    add(0, 0, 16'h0000, 1, 1,  4, 1, 16'h0002, 16'h0006);
    add(0, 0, 16'h0000, 1, 1,  4, 1, 16'h0003, 16'h0007);
    add(0, 0, 16'h0000, 1, 1,  4, 1, 16'h0004, 16'h0008);
    // drain one so buffer holds 5..7, then redirect to 0x0040
    add(0, 0, 16'h0000, 0, 1,  3, 1, 16'h0005, 16'h0008);
    add(0, 1, 16'h0040, 1, 1,  0, 0, 16'h0000, 16'h0040);
    add(0, 0, 16'h0000, 1, 1,  1, 1, 16'h0040, 16'h0041);
    // PC wrap at 0xFFFF
    add(0, 1, 16'hFFFF, 1, 1,  0, 0, 16'h0000, 16'hFFFF);
    add(0, 0, 16'h0000, 1, 0,  1, 1, 16'hFFFF, 16'h0000);
    add(0, 0, 16'h0000, 1, 0,  2, 1, 16'hFFFF, 16'h0001);
    add(0, 0, 16'h0000, 0, 1,  1, 1, 16'h0000, 16'h0001);
    // imemReady toggling 1,0,1,0: PC advances by two, no dup/skip
    add(0, 0, 16'h0000, 1, 1,  1, 1, 16'h0001, 16'h0002);
    add(0, 0, 16'h0000, 0, 1,  0, 0, 16'h0000, 16'h0002);
    add(0, 0, 16'h0000, 1, 1,  1, 1, 16'h0002, 16'h0003);
    add(0, 0, 16'h0000, 0, 1,  0, 0, 16'h0000, 16'h0003);
    // fill to 3, then reset beats a simultaneous redirect and fetch
    add(0, 0, 16'h0000, 1, 0,  1, 1, 16'h0003, 16'h0004);
    add(0, 0, 16'h0000, 1, 0,  2, 1, 16'h0003, 16'h0005);
    add(0, 0, 16'h0000, 1, 0,  3, 1, 16'h0003, 16'h0006);
    add(1, 1, 16'h0040, 1, 1,  0, 0, 16'h0000, 16'h0000);
    add(0, 0, 16'h0000, 0, 0,  0, 0, 16'h0000, 16'h0000);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].redir, vecs[i].rpc, vecs[i].rdy, vecs[i].ordy);
      check_state($sformatf("vec%0d", i), vecs[i].exp_cnt, vecs[i].exp_valid,
                  vecs[i].exp_pc, vecs[i].exp_addr);
    end

    // Pointer wrap: push 0..2, pop 0..1, push 3..5 (write pointer wraps),
    // then drain 2..5 in fetch order.
    for (int i = 0; i < 3; i++) step(0, 0, 16'h0000, 1, 0);
    check_state("wrap.fill3", 3, 1, 16'h0000, 16'h0003);
    step(0, 0, 16'h0000, 0, 1);
    check_state("wrap.pop0", 2, 1, 16'h0001, 16'h0003);
    step(0, 0, 16'h0000, 0, 1);
    check_state("wrap.pop1", 1, 1, 16'h0002, 16'h0003);
    for (int i = 0; i < 3; i++) step(0, 0, 16'h0000, 1, 0);
    check_state("wrap.full", 4, 1, 16'h0002, 16'h0006);
    for (int i = 0; i < 4; i++) begin
      check_state($sformatf("wrap.head%0d", i), 4 - i, 1, 16'(2 + i), 16'h0006);
      step(0, 0, 16'h0000, 0, 1);
    end
    check_state("wrap.empty", 0, 0, 16'h0000, 16'h0006);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
